// File: rtl/rr_decode_arbiter.sv
// Eight-requester round-robin arbiter with one-hot decoded grant, hold timeout
// and a one-cycle guard gap between owners. All outputs are registered.
module rr_decode_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    grant_q, grant_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    logic [2:0] pick;
    logic [2:0] cand;
    logic       pick_vld;
    logic       rel_wd, rel_exp, rel;

    // First requester at or after the priority pointer, wrapping mod 8.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!pick_vld && req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign rel_wd  = !req[idx_q];
    assign rel_exp = (cnt_q == CW'(MAX_HOLD - 1));
    assign rel     = done || rel_wd || rel_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_vld) state_d = StBusy;
            StBusy:  if (rel) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    idx_d   = pick;
                    grant_d = 8'd1 << pick;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CW'(1);
                if (rel) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 3'd1;
                    // Only a pure expiry counts as a forced release.
                    timeout_d = rel_exp && !done && !rel_wd;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Eight-requester round-robin arbiter sharing one resource.
- Produces a 3-bit winner index and its one-hot 3-to-8 decoded grant.
- The one-hot grant drives resource select lines, such as chip selects or mux enables.
- Each grant is held until the owner releases it or a hold-timeout expires. A one-cycle guard gap is inserted between owners.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release. Legal range 2..255.
- CW, 8, width of the hold counter. Must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  8  request vector, bit i = requester i. Level-sensitive.
- done  input  1  release strobe from the current owner. Ignored when no grant is active.
- grant  output  8  one-hot grant, equal to decode(grant_idx) when grant_valid=1, else 8'h00.
- grant_idx  output  3  index of the current or last owner.
- grant_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly released.

Behaviour:
- Reset (async, immediate on rst=1, independent of clk):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- All outputs are registered. No combinational path from req or done to any output.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If req==0, stay in IDLE.
  - Else select the first i scanning ptr, ptr+1, ... ptr+7 (mod 8) with req[i]=1.
  - On the next edge: grant_idx=i, grant=1<<i, grant_valid=1, counter=0, state=BUSY.
  - Latency: req high before edge n gives grant visible after edge n (1 cycle).
- BUSY: counter increments each cycle. Release occurs on the first cycle any of these is true:
  - (a) done=1.
  - (b) req[grant_idx]=0 (requester withdrew).
  - (c) counter==MAX_HOLD-1. Only this condition asserts timeout.
- On a release edge:
  - grant=0, grant_valid=0, ptr=grant_idx+1 (3-bit wrap, 7→0), state=GAP.
  - timeout=1 for exactly that cycle, only when (c) caused the release and neither (a) nor (b) was also true.
- Simultaneous release conditions: a single release occurs. timeout=0 if done or withdrawal coincides with expiry.
- Maximum hold: a grant is visible for at most MAX_HOLD cycles.
- GAP: exactly one cycle with grant=0. Next edge goes to IDLE; req is not evaluated in GAP.
- Owner-to-owner switch: minimum 2 dead cycles (GAP, then IDLE arbitration edge).
- grant_idx holds its last value while grant_valid=0.
- Requests from non-owners while in BUSY are ignored (no preemption).
- done while in IDLE or GAP: no effect.
- Fairness: a continuously requesting set of k requesters is served in strict cyclic order. Each requester waits at most 7 grants.
- rst asserted mid-BUSY: grant drops immediately (async), ptr returns to 0. On rst release, arbitration restarts from requester 0.
- Invariant: popcount(grant) ≤ 1 always, and grant==(grant_valid ? 1<<grant_idx : 0).

Test Plan:
1. rst=1 then release, req=8'h00 for 10 cycles -> grant=00, grant_valid=0, timeout=0 throughout.
2. req=8'h24 (bits 2,5) from reset, done pulsed 3 cycles after each grant -> grant sequence 04, 20, 04, 20. ptr wrap checked. Two dead cycles between grants.
3. req=8'h80 held, done never asserted, MAX_HOLD=16 -> grant=80 for exactly 16 cycles, then timeout=1 for one cycle with grant=00. Regrant of 80 follows two cycles after release.
4. Owner 3 granted, req[3] dropped mid-hold while req[6]=1 -> release next edge with timeout=0, then grant=40 after the GAP and IDLE cycles.
5. done=1 on the same cycle counter==MAX_HOLD-1 -> single release, timeout stays 0.
6. req=8'hFF, grant=10 (owner 4), assert rst asynchronously between edges -> grant=00 immediately. After release, first grant is 01.
